// File: rtl/toggle_decoder_pkg.sv
// rtl/toggle_decoder_pkg.sv - shared state encodings and defaults for toggle_decoder
package toggle_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_STALL  = 2'b10
    } state_t;

    localparam int DEF_CNT_W   = 8;
    localparam int DEF_TIMEOUT = 16;
    localparam int TMR_W       = 8;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop single-bit synchronizer, async active-low reset
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/toggle_decoder.sv
// rtl/toggle_decoder.sv - T flip-flop level decoder, event counter and stall FSM (option TOGGLE_DECODER_SYNC_EN)
module toggle_decoder
    import toggle_decoder_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             q_in,
    input  logic             en,
    input  logic             clr,
    output logic             t_pulse,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic             cnt_ovf,
    output logic [1:0]       state
);

    logic q_d;

    // Priming waits until the synchronizer has flushed its reset zeros.
`ifdef TOGGLE_DECODER_SYNC_EN
    localparam logic [1:0] PRIME_N = 2'd3;

    sync2 u_sync2 (
        .clk (clk),
        .rst (rst),
        .d   (q_in),
        .q   (q_d)
    );
`else
    localparam logic [1:0] PRIME_N = 2'd1;

    assign q_d = q_in;
`endif

    localparam logic [TMR_W-1:0] TMO = TMR_W'(TIMEOUT);

    logic             samp;
    logic             ref_q;
    logic [1:0]       prime_cnt;
    logic             primed;
    logic [TMR_W-1:0] idle_tmr;
    state_t           st;

    assign primed = (prime_cnt == PRIME_N);
    assign state  = st;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp      <= 1'b0;
            ref_q     <= 1'b0;
            prime_cnt <= 2'd0;
            t_pulse   <= 1'b0;
        end else begin
            samp <= q_d;
            if (!primed) begin
                ref_q     <= q_d;
                prime_cnt <= prime_cnt + 2'd1;
                t_pulse   <= 1'b0;
            end else begin
                ref_q   <= samp;
                t_pulse <= samp ^ ref_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st         <= ST_IDLE;
            idle_tmr   <= '0;
            toggle_cnt <= '0;
            cnt_ovf    <= 1'b0;
        end else if (clr) begin
            st         <= ST_IDLE;
            idle_tmr   <= '0;
            toggle_cnt <= '0;
            cnt_ovf    <= 1'b0;
        end else begin
            if (t_pulse && en) begin
                toggle_cnt <= toggle_cnt + CNT_W'(1);
                if (&toggle_cnt) begin
                    cnt_ovf <= 1'b1;
                end
            end
            case (st)
                ST_IDLE: begin
                    if (t_pulse) begin
                        st       <= ST_ACTIVE;
                        idle_tmr <= '0;
                    end
                end
                ST_ACTIVE: begin
                    if (t_pulse) begin
                        idle_tmr <= '0;
                    end else if (idle_tmr < TMO) begin
                        idle_tmr <= idle_tmr + TMR_W'(1);
                        if (idle_tmr == TMO - TMR_W'(1)) begin
                            st <= ST_STALL;
                        end
                    end
                end
                ST_STALL: begin
                    if (t_pulse) begin
                        st       <= ST_ACTIVE;
                        idle_tmr <= '0;
                    end
                end
                default: begin
                    st       <= ST_IDLE;
                    idle_tmr <= '0;
                end
            endcase
        end
    end

endmodule
